ldpc_3gpp_dec_out_buf: RTL

//  Pull-side consumer of the decoder output sink. Drives oreq into the sink and captures its
//  3-tick-latency sop/eop/val/dat stream into a skid FIFO. Re-emits the stream on a

---
 rtl/ldpc_3gpp_dec_out_buf_pkg.sv | 15 +
 rtl/ldpc_3gpp_dec_out_buf_crc_word.sv | 20 ++
 rtl/ldpc_3gpp_dec_out_buf.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ldpc_3gpp_dec_out_buf_pkg.sv
// Shared constants and helpers for the LDPC decoder output buffer.
package ldpc_3gpp_dec_out_buf_pkg;

  localparam logic [23:0] cCRC24A_POLY = 24'h864CFB;
  localparam logic [23:0] cCRC24B_POLY = 24'h800063;
  localparam logic [15:0] cCRC16_POLY  = 16'h1021;

  localparam int unsigned cREQ_LAT = 3;

  // Number of requests still waiting for their data word.
  function automatic logic [1:0] popcount3(input logic [cREQ_LAT-1:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/ldpc_3gpp_dec_out_buf_crc_word.sv
// One pDAT_W-bit parallel CRC step, MSB of the data word processed first.
module ldpc_3gpp_dec_out_buf_crc_word #(
  parameter int unsigned          pDAT_W    = 8,
  parameter int unsigned          pCRC_W    = 24,
  parameter logic [pCRC_W-1:0]    pCRC_POLY = 24'h864CFB
) (
  input  logic [pCRC_W-1:0] icrc,
  input  logic [pDAT_W-1:0] idat,
  output logic [pCRC_W-1:0] ocrc
);

  always_comb begin
    ocrc = icrc;
    for (int i = int'(pDAT_W) - 1; i >= 0; i--) begin
      if (ocrc[pCRC_W-1] ^ idat[i]) ocrc = {ocrc[pCRC_W-2:0], 1'b0} ^ pCRC_POLY;
      else                          ocrc = {ocrc[pCRC_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ldpc_3gpp_dec_out_buf.sv
// Pull-side output buffer of the LDPC decoder: credit-based sink requests, show-ahead skid FIFO.
// Optional per-frame CRC check enabled by defining LDPC_3GPP_DEC_OUT_BUF_CRC_EN.
module ldpc_3gpp_dec_out_buf
  import ldpc_3gpp_dec_out_buf_pkg::*;
#(
  parameter int unsigned       pDAT_W      = 8,
  parameter int unsigned       pTAG_W      = 4,
  parameter int unsigned       pERR_W      = 16,
  parameter int unsigned       pFIFO_DEPTH = 8,
  parameter int unsigned       pCRC_W      = 24,
  parameter logic [pCRC_W-1:0] pCRC_POLY   = cCRC24A_POLY
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              ifull,
  output logic              oreq,
  input  logic              isop,
  input  logic              ieop,
  input  logic              ival,
  input  logic [pDAT_W-1:0] idat,
  input  logic [pTAG_W-1:0] itag,
  input  logic              idecfail,
  input  logic [pERR_W-1:0] ierr,
  input  logic              ordy,
  output logic              oval,
  output logic              osop,
  output logic              oeop,
  output logic [pDAT_W-1:0] odat,
  output logic [pTAG_W-1:0] otag,
  output logic              odecfail,
  output logic [pERR_W-1:0] oerr,
  output logic              ocrc_err
);

  localparam int unsigned cADDR_W = $clog2(pFIFO_DEPTH);
  localparam int unsigned cCNT_W  = cADDR_W + 1;
  localparam int unsigned cSUM_W  = cCNT_W + 2;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [pDAT_W-1:0] dat;
    logic [pTAG_W-1:0] tag;
    logic              decfail;
    logic [pERR_W-1:0] err;
`ifdef LDPC_3GPP_DEC_OUT_BUF_CRC_EN
    logic              crc_err;
`endif
  } entry_t;

  entry_t                r_mem [pFIFO_DEPTH];
  logic [cADDR_W-1:0]    r_wr_ptr;
  logic [cADDR_W-1:0]    r_rd_ptr;
  logic [cCNT_W-1:0]     r_count;
  logic [cREQ_LAT-1:0]   r_req_sr;

  entry_t                w_entry;
  entry_t                w_head;
  logic [1:0]            w_inflight;
  logic                  w_credit_ok;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;

  // Reserve a FIFO slot for every request whose data has not yet returned.
  assign w_inflight  = popcount3(r_req_sr);
  assign w_credit_ok = (cSUM_W'(r_count) + cSUM_W'(w_inflight) + cSUM_W'(1)) <= cSUM_W'(pFIFO_DEPTH);
  assign oreq        = iclkena & ifull & w_credit_ok;

  assign oval   = (r_count != '0);
  assign w_full = (r_count == cCNT_W'(pFIFO_DEPTH));
  assign w_pop  = iclkena & oval & ordy;
  assign w_push = iclkena & ival & (~w_full | w_pop);

`ifdef LDPC_3GPP_DEC_OUT_BUF_CRC_EN
  logic [pCRC_W-1:0] r_crc;
  logic [pCRC_W-1:0] w_crc_base;
  logic [pCRC_W-1:0] w_crc_next;

  // A start-of-frame word restarts the remainder before it is folded in.
  assign w_crc_base = isop ? '0 : r_crc;

  ldpc_3gpp_dec_out_buf_crc_word #(
    .pDAT_W    (pDAT_W),
    .pCRC_W    (pCRC_W),
    .pCRC_POLY (pCRC_POLY)
  ) u_crc_word (
    .icrc (w_crc_base),
    .idat (idat),
    .ocrc (w_crc_next)
  );

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)      r_crc <= '0;
    else if (w_push) r_crc <= w_crc_next;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^pCRC_POLY;
`endif

  always_comb begin
    w_entry         = '0;
    w_entry.sop     = isop;
    w_entry.eop     = ieop;
    w_entry.dat     = idat;
    w_entry.tag     = itag;
    w_entry.decfail = idecfail;
    w_entry.err     = ierr;
`ifdef LDPC_3GPP_DEC_OUT_BUF_CRC_EN
    w_entry.crc_err = ieop & (w_crc_next != '0);
`endif
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_req_sr <= '0;
    end else if (iclkena) begin
      r_req_sr <= {r_req_sr[cREQ_LAT-2:0], oreq};
      if (w_push) r_wr_ptr <= r_wr_ptr + cADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + cADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cCNT_W'(1);
        2'b01:   r_count <= r_count - cCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: every read is qualified by a non-zero count.
  always_ff @(posedge iclk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign osop     = oval & w_head.sop;
  assign oeop     = oval & w_head.eop;
  assign odat     = oval ? w_head.dat : '0;
  assign otag     = oval ? w_head.tag : '0;
  assign odecfail = oval & w_head.decfail;
  assign oerr     = oval ? w_head.err : '0;
`ifdef LDPC_3GPP_DEC_OUT_BUF_CRC_EN
  assign ocrc_err = oval & w_head.eop & w_head.crc_err;
`else
  assign ocrc_err = 1'b0;
`endif

  // Credit accounting makes a push into a full FIFO a sink protocol violation.
  a_no_overflow : assert property (@(posedge iclk) disable iff (ireset)
    !(iclkena && ival && w_full && !w_pop));

endmodule
